// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file.
//   sweep_state_e   - background initialisation sweep FSM state
//   REGFILE_DATA_W  - default register width
//   REGFILE_DEPTH   - default entry count
//   REGFILE_NUM_RD  - default read port count
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_DEPTH  = 32;
  localparam int unsigned REGFILE_NUM_RD = 2;

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } sweep_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one registered read port of the register file.
//
// Ports:
//   clk_i        - clock
//   res_i        - synchronous active-high reset, clears the output register
//   addr_i       - read address
//   mem_i        - current array contents (pre-write view of this edge)
//   byp0_en_i    - main write port commits this cycle (already qualified)
//   byp0_addr_i  - main write address
//   byp0_data_i  - main write data
//   byp1_en_i    - link write port commits this cycle (already qualified)
//   byp1_addr_i  - link write address
//   byp1_data_i  - link write data
//   data_o       - registered read data, valid one cycle after addr_i
//
// Bypass is disabled by tying both byp*_en_i low; the port then always returns
// the array contents as they stood before the edge.
module regfile_rdport #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  input  logic              byp0_en_i,
  input  logic [ADDR_W-1:0] byp0_addr_i,
  input  logic [DATA_W-1:0] byp0_data_i,
  input  logic              byp1_en_i,
  input  logic [ADDR_W-1:0] byp1_addr_i,
  input  logic [DATA_W-1:0] byp1_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    rd_data = mem_i[addr_i];
    // Link port is checked last so it wins when both writes hit this address.
    if (byp0_en_i && (byp0_addr_i == addr_i)) begin
      rd_data = byp0_data_i;
    end
    if (byp1_en_i && (byp1_addr_i == addr_i)) begin
      rd_data = byp1_data_i;
    end
    // Hardwired zero entry overrides any bypass.
    if (ZERO_R0 && (addr_i == '0)) begin
      rd_data = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      data_q <= '0;
    end else begin
      data_q <= rd_data;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports (main and link),
// NUM_RD registered read ports, a registered debug read port and a background
// initialisation sweep that writes each entry with its own index.
//
// Ports:
//   clk         - clock
//   res         - synchronous active-high reset; loads entry i with i
//   wen0/wadd0/wdi0 - main write port
//   wen1/wadd1/wdi1 - link write port (wins on same-address collision)
//   radd        - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   dout        - packed registered read data, port k at [k*DATA_W +: DATA_W]
//   clr         - start the initialisation sweep (ignored while busy)
//   busy        - sweep in progress; writes are dropped while high
//   radd_debug  - debug read address (never bypassed)
//   dout_debug  - registered debug read data
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle committing
// write data to the read ports; otherwise reads see the pre-write value.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = REGFILE_DATA_W,
  parameter int unsigned DEPTH   = REGFILE_DEPTH,
  parameter int unsigned NUM_RD  = REGFILE_NUM_RD,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     wen0,
  input  logic [ADDR_W-1:0]        wadd0,
  input  logic [DATA_W-1:0]        wdi0,
  input  logic                     wen1,
  input  logic [ADDR_W-1:0]        wadd1,
  input  logic [DATA_W-1:0]        wdi1,
  input  logic [NUM_RD*ADDR_W-1:0] radd,
  output logic [NUM_RD*DATA_W-1:0] dout,
  input  logic                     clr,
  output logic                     busy,
  input  logic [ADDR_W-1:0]        radd_debug,
  output logic [DATA_W-1:0]        dout_debug
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic we0;
  logic we1;
  logic byp0_en;
  logic byp1_en;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr) begin
            state_q <= StSweep;
            cnt_q   <= '0;
          end
        end
        StSweep: begin
          if (cnt_q == LastIdx) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == StSweep);

  // ---------------------------------------------------------------------------
  // Write qualification: writes are dropped (not queued) during a sweep, and
  // writes to entry 0 are dropped when it is hardwired to zero.
  // ---------------------------------------------------------------------------
  assign we0 = wen0 && !busy && !res && !(ZERO_R0 && (wadd0 == '0));
  assign we1 = wen1 && !busy && !res && !(ZERO_R0 && (wadd1 == '0));

  // ---------------------------------------------------------------------------
  // Storage array, one register per entry
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [ADDR_W-1:0] Idx = ADDR_W'(i);
    localparam logic [DATA_W-1:0] Init = DATA_W'(i);

    always_ff @(posedge clk) begin
      if (res) begin
        mem_q[i] <= Init;
      end else if (busy) begin
        if (cnt_q == Idx) begin
          mem_q[i] <= Init;
        end
      end else if (we1 && (wadd1 == Idx)) begin
        mem_q[i] <= wdi1;
      end else if (we0 && (wadd0 == Idx)) begin
        mem_q[i] <= wdi0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass enables; we0/we1 are already inactive while busy.
  // ---------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  assign byp0_en = we0;
  assign byp1_en = we1;
`else
  assign byp0_en = 1'b0;
  assign byp1_en = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_rdport (
      .clk_i       (clk),
      .res_i       (res),
      .addr_i      (radd[k*ADDR_W +: ADDR_W]),
      .mem_i       (mem_q),
      .byp0_en_i   (byp0_en),
      .byp0_addr_i (wadd0),
      .byp0_data_i (wdi0),
      .byp1_en_i   (byp1_en),
      .byp1_addr_i (wadd1),
      .byp1_data_i (wdi1),
      .data_o      (dout[k*DATA_W +: DATA_W])
    );
  end

  // Debug port never forwards write data.
  regfile_rdport #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_rdport_debug (
    .clk_i       (clk),
    .res_i       (res),
    .addr_i      (radd_debug),
    .mem_i       (mem_q),
    .byp0_en_i   (1'b0),
    .byp0_addr_i ('0),
    .byp0_data_i ('0),
    .byp1_en_i   (1'b0),
    .byp1_addr_i ('0),
    .byp1_data_i ('0),
    .data_o      (dout_debug)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

  localparam int DataW = 32;
  localparam int Depth = 32;
  localparam int NumRd = 2;
  localparam int AddrW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   res;
  logic                   wen0, wen1, clr;
  logic [AddrW-1:0]       wadd0, wadd1, radd_debug;
  logic [DataW-1:0]       wdi0, wdi1;
  logic [NumRd*AddrW-1:0] radd;
  logic [NumRd*DataW-1:0] dout;
  logic                   busy;
  logic [DataW-1:0]       dout_debug;

  int checks = 0;
  int errors = 0;

  regfile_mp dut (
    .clk        (clk),
    .res        (res),
    .wen0       (wen0),
    .wadd0      (wadd0),
    .wdi0       (wdi0),
    .wen1       (wen1),
    .wadd1      (wadd1),
    .wdi1       (wdi1),
    .radd       (radd),
    .dout       (dout),
    .clr        (clr),
    .busy       (busy),
    .radd_debug (radd_debug),
    .dout_debug (dout_debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DataW-1:0] act,
                       input logic [DataW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an array plus a countdown of remaining sweep cycles.
  // ---------------------------------------------------------------------------
  logic [DataW-1:0] mem_m [Depth];
  logic [DataW-1:0] exp_dout [NumRd];
  logic [DataW-1:0] exp_dbg;
  int               sweep_left = 0;
  bit               exp_busy = 1'b0;
  bit               model_valid = 1'b0;

  function automatic logic [DataW-1:0] model_read(input int a, input bit use_byp);
    logic [DataW-1:0] v;
    v = mem_m[a];
    if (use_byp && Byp && sweep_left == 0) begin
      if (wen0 && int'(wadd0) == a) v = wdi0;
      if (wen1 && int'(wadd1) == a) v = wdi1;
    end
    if (a == 0) v = '0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < Depth; i++) mem_m[i] = DataW'(i);
      for (int k = 0; k < NumRd; k++) exp_dout[k] = '0;
      exp_dbg     = '0;
      sweep_left  = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int k = 0; k < NumRd; k++) exp_dout[k] = model_read(int'(radd[k*AddrW +: AddrW]), 1'b1);
      exp_dbg = model_read(int'(radd_debug), 1'b0);
      if (sweep_left > 0) begin
        mem_m[Depth - sweep_left] = DataW'(Depth - sweep_left);
        sweep_left--;
      end else begin
        if (wen0 && wadd0 != 0) mem_m[wadd0] = wdi0;
        if (wen1 && wadd1 != 0) mem_m[wadd1] = wdi1;
        if (clr) sweep_left = Depth;
      end
    end
    exp_busy = (sweep_left > 0);
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < NumRd; k++)
        check($sformatf("model_dout%0d", k), dout[k*DataW +: DataW], exp_dout[k]);
      check("model_dbg", dout_debug, exp_dbg);
      check("model_busy", {31'b0, busy}, {31'b0, exp_busy});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input int a0, input int a1);
    radd = {AddrW'(a1), AddrW'(a0)};
  endtask

  task automatic count_busy(input string name, input int drop_at, input int clr_at);
    int n;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      wen0  = (i == drop_at);
      wadd0 = 5'd20;
      wdi0  = 32'h0000_BEEF;
      clr   = (i == clr_at);
      cyc();
    end
    wen0 = 1'b0;
    clr  = 1'b0;
    check(name, DataW'(n), 32'd32);
  endtask

  initial begin
    res = 1'b1; wen0 = 1'b0; wen1 = 1'b0; clr = 1'b0;
    wadd0 = '0; wadd1 = '0; wdi0 = '0; wdi1 = '0;
    radd = '0; radd_debug = '0;
    cyc();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dout", dout[31:0], 32'd0);
    check("rst_dbg", dout_debug, 32'd0);
    res = 1'b0;

    // Reset contents
    set_rd(5, 31); radd_debug = 5'd17;
    cyc();
    check("rd_5", dout[31:0], 32'd5);
    check("rd_31", dout[63:32], 32'd31);
    check("dbg_17", dout_debug, 32'd17);

    // Collision on entry 7, same-cycle read on port 0
    wen0 = 1'b1; wadd0 = 5'd7; wdi0 = 32'h0000_AAAA;
    wen1 = 1'b1; wadd1 = 5'd7; wdi1 = 32'h0000_5555;
    set_rd(7, 8);
    cyc();
    check("coll_same", dout[31:0], Byp ? 32'h0000_5555 : 32'd7);
    wen0 = 1'b0; wen1 = 1'b0;
    cyc();
    check("coll_after", dout[31:0], 32'h0000_5555);

    // Entry 0 is hardwired to zero
    wen0 = 1'b1; wadd0 = 5'd0; wdi0 = 32'h0000_FFFF;
    wen1 = 1'b1; wadd1 = 5'd0; wdi1 = 32'h0000_FFFF;
    set_rd(0, 0); radd_debug = 5'd0;
    cyc();
    wen0 = 1'b0; wen1 = 1'b0;
    cyc();
    check("zero_p0", dout[31:0], 32'd0);
    check("zero_dbg", dout_debug, 32'd0);

    // Same-cycle write/read of entry 3; debug never bypasses
    wen0 = 1'b1; wadd0 = 5'd3; wdi0 = 32'h0000_1234;
    set_rd(3, 3); radd_debug = 5'd3;
    cyc();
    check("wr_rd_same", dout[63:32], Byp ? 32'h0000_1234 : 32'd3);
    check("wr_rd_dbg", dout_debug, 32'd3);
    wen0 = 1'b0;
    cyc();
    check("wr_rd_next", dout[31:0], 32'h0000_1234);

    // Sweep: entry 9 restored; wen0 to 20 dropped; clr mid-sweep ignored
    wen0 = 1'b1; wadd0 = 5'd9; wdi0 = 32'h0000_DEAD;
    cyc();
    wen0 = 1'b0; set_rd(9, 20);
    cyc();
    check("pre_sweep_9", dout[31:0], 32'h0000_DEAD);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("sweep_busy_on", {31'b0, busy}, 32'd1);
    count_busy("sweep_len", 25, 5);
    set_rd(9, 20); radd_debug = 5'd3;
    cyc();
    check("post_sweep_9", dout[31:0], 32'd9);
    check("post_sweep_20", dout[63:32], 32'd20);
    check("post_sweep_3", dout_debug, 32'd3);

    // Reset overrides write and clr in the same cycle
    wen0 = 1'b1; wadd0 = 5'd11; wdi0 = 32'h0000_0099;
    wen1 = 1'b1; wadd1 = 5'd12; wdi1 = 32'h0000_0098;
    clr = 1'b1; res = 1'b1;
    cyc();
    wen0 = 1'b0; wen1 = 1'b0; clr = 1'b0; res = 1'b0;
    check("res_ovr_busy", {31'b0, busy}, 32'd0);
    set_rd(11, 12);
    cyc();
    check("res_ovr_11", dout[31:0], 32'd11);
    check("res_ovr_12", dout[63:32], 32'd12);

    // Reset mid-sweep restores all entries and allows a fresh clr
    wen0 = 1'b1; wadd0 = 5'd30; wdi0 = 32'h0000_0077;
    cyc();
    wen0 = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (10) cyc();
    res = 1'b1;
    cyc();
    res = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_dout", dout[31:0], 32'd0);
    clr = 1'b1; set_rd(30, 2);
    cyc();
    clr = 1'b0;
    check("abort_30", dout[31:0], 32'd30);
    check("reclr_busy", {31'b0, busy}, 32'd1);
    count_busy("resweep_len", -1, -1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
